// File: rtl/mssd.sv
// ============================================================================
// Module   : mssd
// Purpose  : Serial frame receiver and 1-to-4 demux clocked by a push-button
//            bit strobe, with remaining-length shown on two seven-seg digits.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mssd (
    input  logic       clk,
    input  logic       reset,
    input  logic       clkPB,
    input  logic       SerIn,
    output logic [3:0] P,
    output logic       serOut_valid,
    output logic       done,
    output logic [6:0] SSD_OUT_LOW,
    output logic [6:0] SSD_OUT_HIGH
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PORT  = 2'd1,
        S_COUNT = 2'd2,
        S_DATA  = 2'd3
    } state_t;

    localparam logic [2:0] C_PORT_LAST  = 3'd1;
    localparam logic [2:0] C_COUNT_LAST = 3'd5;

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic       w_strobe;

    state_t     state_q;
    logic [1:0] port_q;
    logic [5:0] count_q;
    logic [2:0] bits_q;
    logic       done_q;
    logic       valid_q;
    logic [5:0] w_count_shift;

    // clkPB is asynchronous to clk: two flops before the edge detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= clkPB;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign w_strobe      = sync2_q & ~prev_q;
    assign w_count_shift = {count_q[4:0], SerIn};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            port_q  <= 2'd0;
            count_q <= 6'd0;
            bits_q  <= 3'd0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (w_strobe) begin
            case (state_q)
                S_IDLE: begin
                    if (!SerIn) begin
                        done_q  <= 1'b0;
                        port_q  <= 2'd0;
                        count_q <= 6'd0;
                        bits_q  <= 3'd0;
                        state_q <= S_PORT;
                    end
                end
                S_PORT: begin
                    port_q <= {port_q[0], SerIn};
                    if (bits_q == C_PORT_LAST) begin
                        bits_q  <= 3'd0;
                        state_q <= S_COUNT;
                    end else begin
                        bits_q <= bits_q + 3'd1;
                    end
                end
                S_COUNT: begin
                    count_q <= w_count_shift;
                    if (bits_q == C_COUNT_LAST) begin
                        bits_q <= 3'd0;
                        if (w_count_shift == 6'd0) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            valid_q <= 1'b1;
                            state_q <= S_DATA;
                        end
                    end else begin
                        bits_q <= bits_q + 3'd1;
                    end
                end
                S_DATA: begin
                    count_q <= count_q - 6'd1;
                    if (count_q == 6'd1) begin
                        done_q  <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Payload bit is passed straight through so the LED follows the switch.
    always_comb begin
        P = 4'b0000;
        if (valid_q) begin
            P[port_q] = SerIn;
        end
    end

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign serOut_valid = valid_q;
    assign done         = done_q;
    assign SSD_OUT_LOW  = hex_seg(count_q[3:0]);
    assign SSD_OUT_HIGH = hex_seg({2'b00, count_q[5:4]});

endmodule

`default_nettype wire

// File: tb/tb_mssd.sv
// Testbench for mssd: directed and random frames against a frame-level model.
`default_nettype none

module tb_mssd;

    logic       clk;
    logic       reset;
    logic       clkPB;
    logic       SerIn;
    logic [3:0] P;
    logic       serOut_valid;
    logic       done;
    logic [6:0] SSD_OUT_LOW;
    logic [6:0] SSD_OUT_HIGH;

    int n_checks;
    int n_errors;

    logic [6:0] seg_tab [16];

    mssd u_dut (
        .clk          (clk),
        .reset        (reset),
        .clkPB        (clkPB),
        .SerIn        (SerIn),
        .P            (P),
        .serOut_valid (serOut_valid),
        .done         (done),
        .SSD_OUT_LOW  (SSD_OUT_LOW),
        .SSD_OUT_HIGH (SSD_OUT_HIGH)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ssd(input string tag, input int cnt);
        check({tag, "_ssd_lo"}, {25'd0, SSD_OUT_LOW},  {25'd0, seg_tab[cnt % 16]});
        check({tag, "_ssd_hi"}, {25'd0, SSD_OUT_HIGH}, {25'd0, seg_tab[cnt / 16]});
    endtask

    // One clean button press carrying bit b; outputs settled on return.
    task automatic press(input logic b);
        @(negedge clk);
        SerIn = b;
        clkPB = 1'b1;
        repeat (4) @(negedge clk);
        clkPB = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [1:0] port, input int len, input logic [63:0] data);
        logic [5:0] lv;
        int         remaining;
        lv = len[5:0];
        press(1'b0);
        check("start_done_clr", {31'd0, done}, 32'd0);
        check("start_valid", {31'd0, serOut_valid}, 32'd0);
        press(port[1]);
        press(port[0]);
        for (int k = 1; k <= 6; k++) begin
            press(lv[6-k]);
            if (k < 6) check_ssd("hdr_partial", int'(lv) >> (6 - k));
        end
        check_ssd("hdr_len", len);
        if (len == 0) begin
            check("zero_done", {31'd0, done}, 32'd1);
            check("zero_valid", {31'd0, serOut_valid}, 32'd0);
            check("zero_P", {28'd0, P}, 32'd0);
            return;
        end
        remaining = len;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            SerIn = data[i];
            #1;
            check("data_valid", {31'd0, serOut_valid}, 32'd1);
            check("data_P", {28'd0, P}, {28'd0, 4'(data[i]) << port});
            check("data_done", {31'd0, done}, 32'd0);
            press(data[i]);
            remaining--;
            check_ssd("data_cnt", remaining);
        end
        @(negedge clk);
        SerIn = 1'b1;
        #1;
        check("end_done", {31'd0, done}, 32'd1);
        check("end_valid", {31'd0, serOut_valid}, 32'd0);
        check("end_P", {28'd0, P}, 32'd0);
    endtask

    initial begin
        logic [20:0] lit21;
        logic [63:0] d;
        int          len;
        logic [1:0]  port;

        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        clkPB = 1'b0;
        SerIn = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_P", {28'd0, P}, 32'd0);
        check("rst_valid", {31'd0, serOut_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check_ssd("rst", 0);
        reset = 1'b1;

        repeat (4) press(1'b1);
        check("idle_P", {28'd0, P}, 32'd0);
        check("idle_valid", {31'd0, serOut_valid}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check_ssd("idle", 0);

        lit21 = 21'b101001111000111111000;
        d = '0;
        for (int i = 0; i < 21; i++) d[i] = lit21[20-i];
        send_frame(2'd2, 21, d);
        check_ssd("frame21_end", 0);

        send_frame(2'd3, 0, 64'd0);
        send_frame(2'd0, 3, 64'b101);

        for (int f = 0; f < 10; f++) begin
            port = 2'($urandom_range(0, 3));
            len  = (f == 9) ? 63 : int'($urandom_range(0, 30));
            d    = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) press(1'b1);
            send_frame(port, len, d);
        end

        // Abandon a frame five bits into its payload.
        press(1'b0);
        press(1'b1);
        press(1'b0);
        for (int k = 0; k < 6; k++) press(lit21[0] ^ (k % 2 == 1));
        check_ssd("mid_len", 21);
        for (int i = 0; i < 5; i++) press(1'b1);
        check_ssd("mid_cnt", 16);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_P", {28'd0, P}, 32'd0);
        check("mid_rst_valid", {31'd0, serOut_valid}, 32'd0);
        check_ssd("mid_rst", 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) press(1'b1);
        check("post_rst_valid", {31'd0, serOut_valid}, 32'd0);
        check("post_rst_P", {28'd0, P}, 32'd0);
        check("post_rst_done", {31'd0, done}, 32'd0);
        check_ssd("post_rst", 0);
        send_frame(2'd1, 4, 64'b1011);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mssd.md
# mssd

Serial frame receiver and 1-to-4 demultiplexer driven by a manual bit clock. A slow push-button clock (`clkPB`) qualifies one bit per press on `SerIn`. Each frame carries a start bit, a 2-bit destination port, a 6-bit payload length and the payload bits. The block routes payload bits to one of four outputs `P[3:0]` and shows the remaining payload count on two seven-segment digits. It sits between the board's switch/button inputs and the LED/SSD outputs of the lab top level.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (`reset`=0 resets).
- `clkPB`  in  1  push-button bit clock, asynchronous to `clk`; one bit consumed per rising edge.
- `SerIn`  in  1  serial data; idle level 1; MSB-first fields.
- `P`  out  4  demux outputs; only `P[port]` may be non-zero.
- `serOut_valid`  out  1  high while a payload bit is being presented on `P`.
- `done`  out  1  frame completed.
- `SSD_OUT_LOW`  out  7  active-low segments `{g,f,e,d,c,b,a}`, hex digit of `count[3:0]`.
- `SSD_OUT_HIGH`  out  7  same encoding, hex digit of `{2'b00,count[5:4]}`.

## Operation
- **Bit strobe:** `clkPB` passes through a 2-FF synchronizer on `clk`. A rising-edge detector on the synchronized signal gives a 1-cycle `strobe`. `SerIn` is sampled on `strobe`. There is no debounce; one strobe per clean press.
- **IDLE:** on `strobe` with `SerIn`=0 (start bit), clear `done`, go to PORT. A strobe with `SerIn`=1 is ignored.
- **PORT:** 2 strobes shift `SerIn` into `port[1:0]`, MSB first. Then go to COUNT.
- **COUNT:** 6 strobes shift `SerIn` into `count[5:0]`, MSB first. After the 6th strobe:
  - if `count`==0, go to IDLE and set `done`;
  - otherwise go to DATA.
- **DATA:**
  - `serOut_valid`=1.
  - `P[port]`=`SerIn` (combinational); other P bits are 0.
  - Each strobe consumes one bit and decrements `count`.
  - The strobe that brings `count` to 0 sets `done` and returns to IDLE.
- **Outside DATA:** `P`=0 and `serOut_valid`=0.
- **`done`:** level output. It stays high from frame completion until the next start bit is accepted.
- **SSDs:** continuously decode the `count` register, so the display shows the length while it is being shifted in, then the remaining bits.
- **Hex encoding (g..a, active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Reset (asynchronous):**
  - state=IDLE; `port`=0, `count`=0, `done`=0, sync FFs=0;
  - `P`=0, `serOut_valid`=0, both SSDs show "0" (1000000).
  - Reset mid-frame abandons the frame.
- A `clkPB` edge that arrives while reset is asserted is lost.

## Timing
- `strobe` asserts 2–3 `clk` cycles after the `clkPB` rising edge and lasts exactly 1 cycle.
- `clkPB` must stay high for at least 2 `clk` cycles and low for at least 2 `clk` cycles.
- `SerIn` must be stable for the 3 `clk` cycles around `strobe`.
- State, `count` and `done` update on the `clk` edge at which `strobe` is high.
- Outputs reflect the update in the following cycle.
- The falling edge of `clkPB` has no effect.
- Frame length in strobes = 1 + 2 + 6 + `count`; maximum 72.

## Test plan
- Reset asserted: `P`=0000, `serOut_valid`=0, `done`=0, `SSD_OUT_LOW`=`SSD_OUT_HIGH`=1000000.
- Idle bits: 4 strobes with `SerIn`=1 -> state stays IDLE, all outputs unchanged.
- Full frame:
  - start 0, port 1,0, count 0,1,0,1,0,1 -> port=2, count=21, SSD high=1111001 ("1"), low=0010010 ("5"), `serOut_valid`=1.
  - Then 21 data bits 101001111000111111000 -> each appears on `P[2]` only, count decrements to 0.
  - `done`=1, `P`=0, SSDs show "00".
- Zero-length frame: start, port 11, count 000000 -> `done`=1 immediately, `serOut_valid` never high, `P` stays 0.
- Back-to-back frames: after `done`, a new start bit clears `done`. A second frame to port 0 with count 3 drives only `P[0]`.
- Reset mid-DATA (e.g. after 5 of 21 bits) -> IDLE, count=0, `P`=0. The next strobes are ignored until a start bit.
